// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC and buffers {address, instruction} pairs
// between Instruction_Memory and the IFID register in a DEPTH-entry FIFO.
// Optional zero-latency bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic [DATA_W-1:0]          imem_inst_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_addr_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [ADDR_W-1:0]          addr_o,
  output logic [DATA_W-1:0]          inst_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic head_valid_c;
  logic bypass_c;
  logic pop_c;
  logic push_c;
  logic store_c;

  // Handshake decode: redirect suppresses both push and pop.
  always_comb begin
    head_valid_c = (count_q != '0);
    bypass_c     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_c     = !head_valid_c && start_i && !redirect_i && ready_i;
`endif
    pop_c        = head_valid_c && ready_i && !redirect_i;
    push_c       = start_i && !redirect_i && ((count_q < CNT_W'(DEPTH)) || pop_c);
    store_c      = push_c && !bypass_c;
  end

  assign imem_addr_o = pc_q;
  assign valid_o     = head_valid_c || bypass_c;
  assign addr_o      = bypass_c ? pc_q : addr_mem[rd_ptr_q];
  assign inst_o      = bypass_c ? imem_inst_i : inst_mem[rd_ptr_q];
  assign level_o     = count_q;

  // Fetch PC, pointers and occupancy; redirect flushes and retargets.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      pc_q     <= redirect_addr_i;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        pc_q <= pc_q + ADDR_W'(4);
      end
      if (store_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (store_c && !pop_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!store_c && pop_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Entry storage; contents survive reset, only occupancy is cleared.
  always_ff @(posedge clk_i) begin
    if (store_c) begin
      addr_mem[wr_ptr_q] <= pc_q;
      inst_mem[wr_ptr_q] <= imem_inst_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, RESET_PC=0). Works with or
// without FETCH_QUEUE_BYPASS_EN defined.
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] addr_o;
  logic [31:0] inst_o;
  logic [2:0]  level_o;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .imem_addr_o(imem_addr_o),
    .imem_inst_i(imem_inst_i),
    .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .ready_i(ready_i),
    .valid_o(valid_o),
    .addr_o(addr_o),
    .inst_o(inst_o),
    .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Combinational instruction memory model
  assign imem_inst_i = inst_of(imem_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic head(input string tag, input logic [31:0] a);
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_addr"}, addr_o, a);
    check({tag, "_inst"}, inst_o, inst_of(a));
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b0;
    redirect_i = 1'b0; redirect_addr_i = 32'h0;
    #3;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_pc", imem_addr_o, 32'h0);
    step(1);
    rst_i = 1'b0;

    // Fill to DEPTH with consumer stalled
    start_i = 1'b1; ready_i = 1'b0;
    check("fill_pc0", imem_addr_o, 32'h0);
    step(4);
    check("fill_level", 32'(level_o), 32'd4);
    check("fill_pc", imem_addr_o, 32'h10);
    step(1);
    check("full_hold_level", 32'(level_o), 32'd4);
    check("full_hold_pc", imem_addr_o, 32'h10);
    head("full_head", 32'h0);

    // Full steady state: one push and one pop per cycle
    ready_i = 1'b1;
    step(1);
    check("steady1_level", 32'(level_o), 32'd4);
    check("steady1_pc", imem_addr_o, 32'h14);
    head("steady1_head", 32'h4);
    step(1);
    check("steady2_level", 32'(level_o), 32'd4);
    check("steady2_pc", imem_addr_o, 32'h18);
    head("steady2_head", 32'h8);

    // Drain with fetch disabled
    start_i = 1'b0;
    step(1); head("drain1", 32'hC);
    check("drain1_level", 32'(level_o), 32'd3);
    step(1); head("drain2", 32'h10);
    step(1); head("drain3", 32'h14);
    step(1);
    check("drain_empty_valid", 32'(valid_o), 32'd0);
    check("drain_pc_hold", imem_addr_o, 32'h18);
    step(1);
    check("empty_ready_level", 32'(level_o), 32'd0);
    check("empty_ready_valid", 32'(valid_o), 32'd0);

    // Bypass behaviour from empty with ready
    start_i = 1'b1; ready_i = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    head("byp_same", 32'h18);
    check("byp_level", 32'(level_o), 32'd0);
`else
    check("nobyp_same_valid", 32'(valid_o), 32'd0);
    step(1);
    head("nobyp_next", 32'h18);
    check("nobyp_level", 32'(level_o), 32'd1);
`endif

    // Async reset mid-cycle with three entries
    ready_i = 1'b0; start_i = 1'b1;
    rst_i = 1'b1; #1; rst_i = 1'b0;
    step(3);
    check("pre_rst_level", 32'(level_o), 32'd3);
    #2; rst_i = 1'b1; #1;
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_level", 32'(level_o), 32'd0);
    check("midrst_pc", imem_addr_o, 32'h0);
    @(negedge clk_i); rst_i = 1'b0;
    step(3);
    check("refill_level", 32'(level_o), 32'd3);
    check("refill_pc", imem_addr_o, 32'hC);
    head("refill_head", 32'h0);

    // Redirect flushes queue and retargets fetch
    redirect_i = 1'b1; redirect_addr_i = 32'h40; ready_i = 1'b1;
    step(1);
    redirect_i = 1'b0; ready_i = 1'b0;
    #1;
    check("redir_level", 32'(level_o), 32'd0);
    check("redir_valid", 32'(valid_o), 32'd0);
    check("redir_pc", imem_addr_o, 32'h40);
    step(1);
    head("redir_target", 32'h40);
    check("redir_target_level", 32'(level_o), 32'd1);
    check("redir_next_pc", imem_addr_o, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
